// File: rtl/alu_cmd_sequencer_if.sv
// alu_cmd_sequencer_if: command, response and ALU operand/result signals of the ALU command sequencer
interface alu_cmd_sequencer_if #(
  parameter int OPC_W  = 3,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [OPC_W-1:0]  cmd_opcode;
  logic [DATA_W-1:0] cmd_op1;
  logic [DATA_W-1:0] cmd_op2;
  logic              cmd_chain;
  logic [OPC_W-1:0]  alu_opcode;
  logic [DATA_W-1:0] alu_op1;
  logic [DATA_W-1:0] alu_op2;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic              alu_zero;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_carry;
  logic              rsp_zero;
  logic              rsp_err;
  logic [CNT_W-1:0]  op_count;
  modport master (
    output cmd_valid, cmd_opcode, cmd_op1, cmd_op2, cmd_chain, rsp_ready,
           alu_result, alu_carry, alu_zero,
    input  cmd_ready, alu_opcode, alu_op1, alu_op2, rsp_valid, rsp_result,
           rsp_carry, rsp_zero, rsp_err, op_count
  );
  modport slave (
    input  cmd_valid, cmd_opcode, cmd_op1, cmd_op2, cmd_chain, rsp_ready,
           alu_result, alu_carry, alu_zero,
    output cmd_ready, alu_opcode, alu_op1, alu_op2, rsp_valid, rsp_result,
           rsp_carry, rsp_zero, rsp_err, op_count
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: issues one command at a time to a registered ALU and returns its captured result
module alu_cmd_sequencer #(
  parameter int OPC_W  = 3,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input logic clk,
  input logic rst,
  alu_cmd_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;
  state_t            state_q, state_d;
  logic [OPC_W-1:0]  alu_opcode_q, alu_opcode_d;
  logic [DATA_W-1:0] alu_op1_q, alu_op1_d;
  logic [DATA_W-1:0] alu_op2_q, alu_op2_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic              rsp_carry_q, rsp_carry_d;
  logic              rsp_zero_q, rsp_zero_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              acc, legal, ok, ill, capt;
  assign acc   = bus.cmd_valid && state_q == IDLE;
  assign legal = bus.cmd_opcode <= OPC_W'(3);
  assign ok    = acc && legal;
  assign ill   = acc && !legal;
  assign capt  = state_q == CAPT;
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q == IDLE  ? (acc ? (legal ? ISSUE : RESP) : IDLE) :
              state_q == ISSUE ? CAPT :
              state_q == CAPT  ? RESP :
              (bus.rsp_ready ? IDLE : RESP);
  end
  always_comb begin
    bus.cmd_ready = state_q == IDLE && !rst;
    bus.rsp_valid = state_q == RESP;
  end
  always_comb begin
    alu_opcode_d = ok ? bus.cmd_opcode : alu_opcode_q;
    alu_op1_d    = ok ? (bus.cmd_chain ? last_q : bus.cmd_op1) : alu_op1_q;
    alu_op2_d    = ok ? bus.cmd_op2 : alu_op2_q;
    rsp_result_d = capt ? bus.alu_result : ill ? '0 : rsp_result_q;
    rsp_carry_d  = capt ? bus.alu_carry : ill ? 1'b0 : rsp_carry_q;
    rsp_zero_d   = capt ? bus.alu_zero : ill ? 1'b0 : rsp_zero_q;
    rsp_err_d    = capt ? 1'b0 : ill ? 1'b1 : rsp_err_q;
    last_d       = capt ? bus.alu_result : last_q;
    cnt_d        = capt && cnt_q != '1 ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      alu_opcode_q <= '0;
      alu_op1_q    <= '0;
      alu_op2_q    <= '0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      last_q       <= '0;
      cnt_q        <= '0;
    end else begin
      alu_opcode_q <= alu_opcode_d;
      alu_op1_q    <= alu_op1_d;
      alu_op2_q    <= alu_op2_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
    end
  assign bus.alu_opcode = alu_opcode_q;
  assign bus.alu_op1    = alu_op1_q;
  assign bus.alu_op2    = alu_op2_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_carry  = rsp_carry_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.op_count   = cnt_q;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: table-driven and randomized checks of the sequencer against a registered-ALU model
module tb_alu_cmd_sequencer;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  logic [63:0] mdl_last = '0;
  logic [CW-1:0] mdl_cnt = '0;
  logic [64:0] alu_w = '0;
  typedef struct {
    logic [2:0]  opc;
    logic [63:0] a, b;
    logic        ch;
    int          stall;
    logic [63:0] r;
    logic        c, z, e;
  } vec_t;
  vec_t tv[10];

  always #5 clk = ~clk;

  alu_cmd_sequencer_if #(.CNT_W(CW)) bus ();
  alu_cmd_sequencer #(.OPC_W(3), .DATA_W(64), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic logic [64:0] ref_alu(input logic [2:0] opc, input logic [63:0] a, b);
    case (opc)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} - {1'b0, b};
      3'd2:    return {1'b0, a} + 65'd1;
      3'd3:    return {1'b0, a} - 65'd1;
      default: return '0;
    endcase
  endfunction

  always_ff @(posedge clk) alu_w <= ref_alu(bus.alu_opcode, bus.alu_op1, bus.alu_op2);
  assign bus.alu_result = alu_w[63:0];
  assign bus.alu_carry  = alu_w[64];
  assign bus.alu_zero   = alu_w == 65'd0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic send(input logic [2:0] opc, input logic [63:0] a, b, input logic ch, input int stall,
                      input logic [63:0] er, input logic ec, ez, ee);
    logic [63:0] op1e, p1, p2, w_lo;
    logic [2:0]  po;
    logic [64:0] w;
    int t;
    op1e = ch ? mdl_last : a;
    po = bus.alu_opcode; p1 = bus.alu_op1; p2 = bus.alu_op2;
    bus.cmd_valid = 1'b1; bus.cmd_opcode = opc; bus.cmd_op1 = a; bus.cmd_op2 = b; bus.cmd_chain = ch;
    bus.rsp_ready = 1'b0;
    t = 0;
    while (!bus.cmd_ready && t < 8) begin @(negedge clk); t++; end
    chk("cmd_ready_idle", 64'(bus.cmd_ready), 64'd1);
    @(negedge clk);
    bus.cmd_opcode = 3'($urandom_range(0, 7)); bus.cmd_op1 = {$urandom, $urandom};
    bus.cmd_op2 = {$urandom, $urandom}; bus.cmd_chain = 1'($urandom);
    t = 1;
    while (!bus.rsp_valid && t < 8) begin @(negedge clk); t++; end
    chk("latency", 64'(t), ee ? 64'd1 : 64'd3);
    chk("alu_opcode", 64'(bus.alu_opcode), ee ? 64'(po) : 64'(opc));
    chk("alu_op1", bus.alu_op1, ee ? p1 : op1e);
    chk("alu_op2", bus.alu_op2, ee ? p2 : b);
    chk("rsp_result", bus.rsp_result, er);
    chk("rsp_flags", {61'd0, bus.rsp_carry, bus.rsp_zero, bus.rsp_err}, {61'd0, ec, ez, ee});
    if (!ee) begin
      w = ref_alu(opc, op1e, b);
      w_lo = w[63:0];
      mdl_last = w_lo;
      if (mdl_cnt != '1) mdl_cnt = mdl_cnt + 1'b1;
    end
    chk("op_count", 64'(bus.op_count), 64'(mdl_cnt));
    repeat (stall) begin
      @(negedge clk);
      chk("hold_valid", 64'(bus.rsp_valid), 64'd1);
      chk("hold_result", bus.rsp_result, er);
      chk("hold_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0; bus.cmd_valid = 1'b0;
    chk("rsp_dropped", 64'(bus.rsp_valid), 64'd0);
    chk("back_idle", 64'(bus.cmd_ready), 64'd1);
  endtask

  initial begin
    logic [2:0]  opc;
    logic [63:0] a, b, op1e;
    logic        ch;
    logic [64:0] w;
    tv[0] = '{3'd0, 64'd5, 64'd7, 1'b0, 5, 64'd12, 1'b0, 1'b0, 1'b0};
    tv[1] = '{3'd1, 64'd3, 64'd5, 1'b0, 0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0};
    tv[2] = '{3'd1, 64'd9, 64'd9, 1'b0, 1, 64'd0, 1'b0, 1'b1, 1'b0};
    tv[3] = '{3'd0, 64'd10, 64'd20, 1'b0, 0, 64'd30, 1'b0, 1'b0, 1'b0};
    tv[4] = '{3'd1, 64'hDEAD, 64'd5, 1'b1, 2, 64'd25, 1'b0, 1'b0, 1'b0};
    tv[5] = '{3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1'b0, 0, 64'd0, 1'b1, 1'b0, 1'b0};
    tv[6] = '{3'd6, 64'd44, 64'd55, 1'b0, 3, 64'd0, 1'b0, 1'b0, 1'b1};
    tv[7] = '{3'd0, 64'hBEEF, 64'd1, 1'b1, 0, 64'd1, 1'b0, 1'b0, 1'b0};
    tv[8] = '{3'd3, 64'd0, 64'd9, 1'b0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
    tv[9] = '{3'd7, 64'd1, 64'd1, 1'b1, 0, 64'd0, 1'b0, 1'b0, 1'b1};
    bus.cmd_valid = 1'b0; bus.cmd_opcode = '0; bus.cmd_op1 = '0; bus.cmd_op2 = '0;
    bus.cmd_chain = 1'b0; bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_alu_op1", bus.alu_op1, 64'd0);
    chk("rst_result", bus.rsp_result, 64'd0);
    chk("rst_count", 64'(bus.op_count), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 64'(bus.cmd_ready), 64'd1);
    for (int i = 0; i < 10; i++)
      send(tv[i].opc, tv[i].a, tv[i].b, tv[i].ch, tv[i].stall, tv[i].r, tv[i].c, tv[i].z, tv[i].e);
    for (int i = 0; i < 40; i++) begin
      opc = $urandom_range(0, 9) < 8 ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
      case ($urandom_range(0, 3))
        0:       a = '1;
        1:       a = 64'($urandom_range(0, 3));
        default: a = {$urandom, $urandom};
      endcase
      b = $urandom_range(0, 1) ? a : {$urandom, $urandom};
      ch = 1'($urandom);
      op1e = ch ? mdl_last : a;
      w = ref_alu(opc, op1e, b);
      if (opc > 3'd3) send(opc, a, b, ch, $urandom_range(0, 3), 64'd0, 1'b0, 1'b0, 1'b1);
      else send(opc, a, b, ch, $urandom_range(0, 3), w[63:0], w[64], w == 65'd0, 1'b0);
    end
    chk("count_saturated", 64'(bus.op_count), 64'(mdl_cnt));
    bus.cmd_valid = 1'b1; bus.cmd_opcode = 3'd0; bus.cmd_op1 = 64'd100; bus.cmd_op2 = 64'd200;
    bus.cmd_chain = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    chk("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("midrst_alu_op1", bus.alu_op1, 64'd0);
    chk("midrst_alu_op2", bus.alu_op2, 64'd0);
    chk("midrst_count", 64'(bus.op_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    mdl_last = '0; mdl_cnt = '0;
    repeat (3) begin
      @(negedge clk);
      chk("no_rsp_after_rst", 64'(bus.rsp_valid), 64'd0);
    end
    send(3'd2, 64'h1234, 64'd0, 1'b1, 0, 64'd1, 1'b0, 1'b0, 1'b0);
    send(3'd0, 64'd1, 64'd1, 1'b0, 0, 64'd2, 1'b0, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
